// File: rtl/io_port_bridge.sv
// Processor I/O port bridge: TX FIFO toward the device, RX holding register
// toward the processor, and a rate-limited interrupt pulse per captured word.
// Optional macro IO_INT_MASK_EN adds the int_en interrupt mask input.
module io_port_bridge #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned INT_GAP    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           cpu_out_data,
    input  logic                        cpu_out_wr,
    output logic [DATA_W-1:0]           cpu_in_data,
    input  logic                        cpu_in_rd,
    output logic                        cpu_int,
`ifdef IO_INT_MASK_EN
    input  logic                        int_en,
`endif
    output logic [DATA_W-1:0]           dev_tx_data,
    output logic                        dev_tx_valid,
    input  logic                        dev_tx_ready,
    input  logic [DATA_W-1:0]           dev_rx_data,
    input  logic                        dev_rx_valid,
    output logic                        dev_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] tx_count,
    output logic                        tx_drop
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned GAP_W = (INT_GAP > 2) ? $clog2(INT_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } int_state_t;

    // ---------------- TX FIFO (first-word-fall-through) ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              full;

    assign full         = (tx_count == CW'(FIFO_DEPTH));
    assign dev_tx_valid = (tx_count != '0);
    assign dev_tx_data  = mem[rd_ptr];
    assign pop          = dev_tx_valid & dev_tx_ready;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign push         = cpu_out_wr & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_out_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
            tx_drop  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (cpu_out_wr & ~push) begin
                tx_drop <= 1'b1;
            end
        end
    end

    // ---------------- RX holding register ----------------
    logic rx_full;
    logic capture;

    assign dev_rx_ready = ~rx_full;
    assign capture      = dev_rx_valid & ~rx_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_in_data <= '0;
            rx_full     <= 1'b0;
        end else if (capture) begin
            cpu_in_data <= dev_rx_data;
            rx_full     <= 1'b1;
        end else if (cpu_in_rd & rx_full) begin
            rx_full <= 1'b0;
        end
    end

    // ---------------- Interrupt pulse FSM ----------------
    int_state_t        state;
    int_state_t        state_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_next;
    logic              pending;
    logic              pending_next;
    logic              cpu_int_next;
    logic              int_ok;
    logic              request;

`ifdef IO_INT_MASK_EN
    assign int_ok = int_en;
`else
    assign int_ok = 1'b1;
`endif

    assign request = pending | capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            pending <= 1'b0;
            cpu_int <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
            pending <= pending_next;
            cpu_int <= cpu_int_next;
        end
    end

    // Leaving GAP with a request waiting goes straight to PULSE so that pulse
    // starts are exactly INT_GAP cycles apart under back-to-back captures.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request & int_ok) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                state_next = GAP;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = (request & int_ok) ? PULSE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        gap_cnt_next = gap_cnt;
        pending_next = request;
        cpu_int_next = 1'b0;
        if (state_next == PULSE) begin
            cpu_int_next = 1'b1;
            pending_next = 1'b0;
        end
        if (state == PULSE) begin
            gap_cnt_next = GAP_W'(INT_GAP - 2);
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt_next = gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: directed scenarios plus random
// traffic, compared every cycle against a queue/timestamp reference model.
module tb_io_port_bridge;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned INT_GAP    = 8;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_rd;
    logic              cpu_int;
    logic              int_en;
    logic [DATA_W-1:0] dev_tx_data;
    logic              dev_tx_valid;
    logic              dev_tx_ready;
    logic [DATA_W-1:0] dev_rx_data;
    logic              dev_rx_valid;
    logic              dev_rx_ready;
    logic [CW-1:0]     tx_count;
    logic              tx_drop;

    always #5 clk = ~clk;

    io_port_bridge #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .INT_GAP   (INT_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_out_data(cpu_out_data),
        .cpu_out_wr  (cpu_out_wr),
        .cpu_in_data (cpu_in_data),
        .cpu_in_rd   (cpu_in_rd),
        .cpu_int     (cpu_int),
`ifdef IO_INT_MASK_EN
        .int_en      (int_en),
`endif
        .dev_tx_data (dev_tx_data),
        .dev_tx_valid(dev_tx_valid),
        .dev_tx_ready(dev_tx_ready),
        .dev_rx_data (dev_rx_data),
        .dev_rx_valid(dev_rx_valid),
        .dev_rx_ready(dev_rx_ready),
        .tx_count    (tx_count),
        .tx_drop     (tx_drop)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] log_q[$];
    int                pulse_at[$];
    bit                m_drop;
    bit                m_full;
    bit                m_int;
    bit                m_pend;
    logic [DATA_W-1:0] m_in;
    int                cyc;
    int                last_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop     = 1'b0;
        m_full     = 1'b0;
        m_in       = '0;
        m_int      = 1'b0;
        m_pend     = 1'b0;
        last_pulse = -1000;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit cap;
        bit req;
        if ((mq.size() != 0) && dev_tx_ready) begin
            log_q.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (cpu_out_wr) begin
            if (mq.size() < int'(FIFO_DEPTH)) mq.push_back(cpu_out_data);
            else m_drop = 1'b1;
        end
        cap = dev_rx_valid && !m_full;
        if (cap) begin
            m_in   = dev_rx_data;
            m_full = 1'b1;
        end else if (cpu_in_rd && m_full) begin
            m_full = 1'b0;
        end
        req = m_pend || cap;
        if (req && int_en && (cyc - last_pulse >= int'(INT_GAP))) begin
            m_int      = 1'b1;
            last_pulse = cyc;
            m_pend     = 1'b0;
        end else begin
            m_int  = 1'b0;
            m_pend = req;
        end
        cyc++;
    endtask

    task automatic compare();
        check("tx_count", 32'(tx_count), 32'(mq.size()));
        check("tx_valid", 32'(dev_tx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("tx_data", 32'(dev_tx_data), 32'(mq[0]));
        check("tx_drop", 32'(tx_drop), 32'(m_drop));
        check("in_data", 32'(cpu_in_data), 32'(m_in));
        check("rx_ready", 32'(dev_rx_ready), 32'(!m_full));
        check("cpu_int", 32'(cpu_int), 32'(m_int));
        if (cpu_int) pulse_at.push_back(cyc);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        cpu_out_wr   = 1'b0;
        cpu_out_data = '0;
        dev_tx_ready = 1'b0;
        dev_rx_valid = 1'b0;
        dev_rx_data  = '0;
        cpu_in_rd    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        compare();
    endtask

    initial begin
        int diff;
        bit found;
        idle_inputs();
        int_en = 1'b1;
        reset  = 1'b1;
        cyc    = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_count", 32'(tx_count), 32'd0);
        check("rst_int", 32'(cpu_int), 32'd0);
        check("rst_ready", 32'(dev_rx_ready), 32'd1);
        check("rst_in_data", 32'(cpu_in_data), 32'd0);

        // Three writes held, then drained in order
        for (int i = 0; i < 3; i++) begin
            cpu_out_wr   = 1'b1;
            cpu_out_data = 16'(16'h0011 * (i + 1));
            cycle();
        end
        cpu_out_wr = 1'b0;
        check("t1_count", 32'(tx_count), 32'd3);
        check("t1_head", 32'(dev_tx_data), 32'h0011);
        log_q.delete();
        dev_tx_ready = 1'b1;
        repeat (3) cycle();
        dev_tx_ready = 1'b0;
        check("t1_empty", 32'(tx_count), 32'd0);
        check("t1_popped", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            check("t1_pop0", 32'(log_q[0]), 32'h0011);
            check("t1_pop1", 32'(log_q[1]), 32'h0022);
            check("t1_pop2", 32'(log_q[2]), 32'h0033);
        end

        // Fill, push+pop at full, then overflow
        for (int i = 0; i < 8; i++) begin
            cpu_out_wr   = 1'b1;
            cpu_out_data = 16'(16'h0100 + i);
            cycle();
        end
        check("t2_full", 32'(tx_count), 32'd8);
        check("t2_nodrop", 32'(tx_drop), 32'd0);
        cpu_out_data = 16'h0200;
        dev_tx_ready = 1'b1;
        cycle();
        check("t2_pushpop_cnt", 32'(tx_count), 32'd8);
        check("t2_pushpop_drop", 32'(tx_drop), 32'd0);
        cpu_out_data = 16'h0999;
        dev_tx_ready = 1'b0;
        cycle();
        cpu_out_wr = 1'b0;
        check("t2_drop", 32'(tx_drop), 32'd1);
        check("t2_cnt", 32'(tx_count), 32'd8);
        log_q.delete();
        dev_tx_ready = 1'b1;
        repeat (8) cycle();
        dev_tx_ready = 1'b0;
        found = 1'b0;
        foreach (log_q[i]) if (log_q[i] == 16'h0999) found = 1'b1;
        check("t2_lost_word", 32'(found), 32'd0);
        check("t2_drained", 32'(log_q.size()), 32'd8);
        if (log_q.size() == 8) check("t2_last", 32'(log_q[7]), 32'h0200);

        // Single capture and interrupt pulse
        do_reset();
        dev_rx_valid = 1'b1;
        dev_rx_data  = 16'hBEEF;
        cycle();
        dev_rx_valid = 1'b0;
        check("t3_data", 32'(cpu_in_data), 32'hBEEF);
        check("t3_notready", 32'(dev_rx_ready), 32'd0);
        check("t3_int_hi", 32'(cpu_int), 32'd1);
        cycle();
        check("t3_int_lo", 32'(cpu_int), 32'd0);
        cpu_in_rd = 1'b1;
        cycle();
        cpu_in_rd = 1'b0;
        check("t3_ready", 32'(dev_rx_ready), 32'd1);
        check("t3_hold", 32'(cpu_in_data), 32'hBEEF);

        // Two captures two cycles apart
        repeat (10) cycle();
        pulse_at.delete();
        dev_rx_valid = 1'b1;
        dev_rx_data  = 16'h0A0A;
        cycle();
        dev_rx_valid = 1'b0;
        cpu_in_rd    = 1'b1;
        cycle();
        cpu_in_rd    = 1'b0;
        dev_rx_valid = 1'b1;
        dev_rx_data  = 16'h0B0B;
        cycle();
        dev_rx_valid = 1'b0;
        cpu_in_rd    = 1'b1;
        cycle();
        cpu_in_rd = 1'b0;
        repeat (14) cycle();
        check("t4_pulses", 32'(pulse_at.size()), 32'd2);
        diff = (pulse_at.size() >= 2) ? pulse_at[1] - pulse_at[0] : -1;
        check("t4_spacing", 32'(diff), 32'(INT_GAP));

        // Reset during PULSE
        repeat (10) cycle();
        dev_rx_valid = 1'b1;
        dev_rx_data  = 16'h5555;
        cycle();
        dev_rx_valid = 1'b0;
        check("t5_pulse", 32'(cpu_int), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_int_async", 32'(cpu_int), 32'd0);
        check("t5_ready_async", 32'(dev_rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pulse_at.delete();
        repeat (12) cycle();
        check("t5_no_pulse", 32'(pulse_at.size()), 32'd0);

`ifdef IO_INT_MASK_EN
        // Masked capture fires on unmask
        int_en       = 1'b0;
        dev_rx_valid = 1'b1;
        dev_rx_data  = 16'h1234;
        cycle();
        dev_rx_valid = 1'b0;
        repeat (3) cycle();
        check("t6_masked", 32'(cpu_int), 32'd0);
        int_en = 1'b1;
        cycle();
        check("t6_unmask", 32'(cpu_int), 32'd1);
        cpu_in_rd = 1'b1;
        cycle();
        cpu_in_rd = 1'b0;
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cpu_out_wr   = ($urandom_range(0, 1) == 1);
            cpu_out_data = 16'($urandom);
            dev_tx_ready = ($urandom_range(0, 2) != 0);
            dev_rx_valid = ($urandom_range(0, 3) == 0);
            dev_rx_data  = 16'($urandom);
            cpu_in_rd    = ($urandom_range(0, 2) == 0);
`ifdef IO_INT_MASK_EN
            int_en       = ($urandom_range(0, 3) != 0);
`endif
            cycle();
        end
        idle_inputs();
        int_en = 1'b1;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
